mac_frame_sequencer: RTL and testbench
======================================

Name: mac_frame_sequencer

Overview:
- Controller that sequences the 8-bit-in / 16-bit-out neuron MAC through one complete inference frame.
- Frame steps: clear accumulator, load 4 weights, stream 4 input samples with one accumulate step each, wait for the MAC pipeline, capture the result, apply a threshold to produce a spike.
- Sits between the host-side configuration and stream interfaces and the MAC's control pins (in, ld, ld1..ld4, clken, rst, out).

Parameters:
- DW, 8, MAC data width (inputs and weights).
- OW, 16, MAC result width.
- MAC_LAT, 2, cycles from the last clken step until mac_out is valid (≥1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- w_wr  in  1  weight write strobe.
- w_addr  in  2  weight index 0..3.
- w_data  in  DW  weight value.
- thr  in  OW  spike threshold (unsigned), sampled at frame start.
- start  in  1  frame request pulse/level.
- abort  in  1  abort current frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted.
- in_data  in  DW  input sample.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- result  out  OW  captured MAC result.
- spike  out  1  result >= thr.
- busy  out  1  high in every state except IDLE.
- mac_in  out  DW  data to MAC.
- mac_ld  out  1  MAC input-sample load.
- mac_ld1..mac_ld4  out  1 each  MAC weight 0..3 load.
- mac_clken  out  1  MAC accumulate step.
- mac_rst  out  1  MAC accumulator clear (active-high).
- mac_out  in  OW  MAC result.

Behaviour:
- Reset (async): state IDLE; all outputs 0; the 4 shadow weights, 4 active weights and thr_q are cleared to 0.
- Shadow weights: w_wr writes w_data into shadow[w_addr] on any cycle, in any state.
- start accepted only in IDLE. On acceptance:
  - shadow weights are copied to active weights;
  - thr is latched into thr_q;
  - a w_wr in the same cycle lands in shadow only and is not used this frame.
- start in any other state is ignored; it is not queued.
- States and transitions, one state per cycle unless noted:
  - IDLE -> CLR on start.
  - CLR: mac_rst=1.
  - LW0..LW3: mac_in = active weight k; mac_ld(k+1)=1.
  - IN_LD(i): in_ready=1; stays in IN_LD while in_valid=0. When in_valid=1: mac_in=in_data, mac_ld=1 -> STEP(i).
  - STEP(i): mac_clken=1. Goes to IN_LD(i+1) for i<3; otherwise to WAIT.
  - WAIT: lasts MAC_LAT cycles.
  - CAP: result<=mac_out; spike<=(mac_out>=thr_q) -> DONE.
  - DONE: out_valid=1, result and spike held stable until out_valid && out_ready, then -> IDLE.
- Latency: with in_valid held high, out_valid rises after edge 14+MAC_LAT, counting the start-accepting edge as 0 (16 for the default MAC_LAT=2). Each cycle in_valid is low adds one cycle.
- Control outputs:
  - mac_ld, mac_ld1..4, mac_clken and mac_rst are single-cycle pulses and mutually exclusive.
  - mac_in = 0 whenever no load pulse is active.
  - All control outputs are registered or decoded from registered state, glitch-free.
- in_ready is high only in IN_LD. Exactly 4 samples are consumed per frame.
- abort: from any state other than IDLE and DONE -> next state CLR-then-IDLE (ABRT: mac_rst=1 for one cycle, then IDLE). No out_valid is produced and previously captured result/spike are unchanged. abort in IDLE or DONE is ignored. abort has priority over in_valid in the same cycle; that sample is not accepted.
- Comparison is unsigned OW-bit. thr=0 always spikes.
- rst mid-frame: immediate return to IDLE with all outputs 0. The MAC's own state is not touched by this block.

Test Plan:
- Reset then idle: after rst deassert -> busy=0, all mac_* outputs 0, out_valid=0; start with no weights written -> weights loaded are 0,0,0,0.
- Nominal frame:
  - stimulus: weights {3,5,7,9}, thr=100, start, in_valid held with samples {1,2,3,4}, MAC model returns 3+10+21+36=70;
  - response: pulse order mac_rst, ld1..ld4 (mac_in 3,5,7,9), then ld/clken ×4; out_valid at cycle 16, result=70, spike=0; with thr=70 -> spike=1.
- Stalls and backpressure: in_valid low 3 cycles before sample 2 -> out_valid at cycle 19; out_ready held low 5 cycles -> result stable, busy=1, start ignored.
- Shadow isolation: w_wr addr 1 = 0xFF during IN_LD(0) -> current frame uses the old weight; the next frame drives mac_in=0xFF with mac_ld2.
- Abort: abort asserted in STEP(2) -> one mac_rst pulse, then IDLE; out_valid never asserted, result keeps its previous value, no further in_ready.
- Async reset mid-WAIT: rst pulsed between edges -> outputs 0 immediately without a clock edge; the next start runs a full frame correctly.

Source files
------------

// File: rtl/mac_frame_sequencer.sv
// mac_frame_sequencer
// Walks the neuron MAC through one inference frame: clear, load 4 weights,
// stream 4 samples (load + accumulate each), wait for the MAC pipeline,
// capture the result and compare it against a latched threshold.
// Weights are written into a shadow bank at any time and copied into the
// active bank only when a frame is accepted, so a frame never sees a
// half-updated weight set.
module mac_frame_sequencer #(
    parameter int DW      = 8,
    parameter int OW      = 16,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_wr,
    input  logic [1:0]    w_addr,
    input  logic [DW-1:0] w_data,
    input  logic [OW-1:0] thr,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] result,
    output logic          spike,
    output logic          busy,
    output logic [DW-1:0] mac_in,
    output logic          mac_ld,
    output logic          mac_ld1,
    output logic          mac_ld2,
    output logic          mac_ld3,
    output logic          mac_ld4,
    output logic          mac_clken,
    output logic          mac_rst,
    input  logic [OW-1:0] mac_out
);

    localparam int WCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_LW, S_IN, S_STEP, S_WAIT, S_CAP, S_DONE, S_ABRT
    } state_t;

    state_t               state;
    logic [3:0][DW-1:0]   shadow;
    logic [3:0][DW-1:0]   act;
    logic [OW-1:0]        thr_q;
    logic [1:0]           k;
    logic [1:0]           k_nxt;
    logic [WCW-1:0]       wcnt;
    logic [3:0]           ld_w;
    logic [DW-1:0]        mac_in_q;
    logic                 abort_take;

    assign k_nxt = k + 2'd1;

    // Abort only cuts a frame that is actually in flight; DONE keeps its
    // result and ABRT is already on its way back to IDLE.
    assign abort_take = abort && (state != S_IDLE) && (state != S_DONE) &&
                        (state != S_ABRT);

    // The sample load has to follow in_valid in the same cycle, so it is the
    // one pulse decoded from state plus input; abort suppresses it.
    assign mac_ld  = (state == S_IN) && in_valid && !abort;
    assign mac_in  = mac_ld ? in_data : mac_in_q;
    assign mac_ld1 = ld_w[0];
    assign mac_ld2 = ld_w[1];
    assign mac_ld3 = ld_w[2];
    assign mac_ld4 = ld_w[3];

    // Frame FSM; every pulse and status output is set on the transition into
    // the state that owns it and defaults back to 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shadow    <= '0;
            act       <= '0;
            thr_q     <= '0;
            k         <= '0;
            wcnt      <= '0;
            ld_w      <= '0;
            mac_in_q  <= '0;
            mac_rst   <= 1'b0;
            mac_clken <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            spike     <= 1'b0;
        end else begin
            if (w_wr) shadow[w_addr] <= w_data;
            mac_rst   <= 1'b0;
            mac_clken <= 1'b0;
            ld_w      <= '0;
            mac_in_q  <= '0;
            if (abort_take) begin
                state    <= S_ABRT;
                mac_rst  <= 1'b1;
                in_ready <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        act     <= shadow;
                        thr_q   <= thr;
                        state   <= S_CLR;
                        mac_rst <= 1'b1;
                        busy    <= 1'b1;
                    end
                    S_CLR: begin
                        state    <= S_LW;
                        k        <= 2'd0;
                        ld_w     <= 4'b0001;
                        mac_in_q <= act[0];
                    end
                    S_LW: if (k == 2'd3) begin
                        state    <= S_IN;
                        k        <= 2'd0;
                        in_ready <= 1'b1;
                    end else begin
                        k        <= k_nxt;
                        ld_w     <= 4'b0001 << k_nxt;
                        mac_in_q <= act[k_nxt];
                    end
                    S_IN: if (in_valid) begin
                        state     <= S_STEP;
                        in_ready  <= 1'b0;
                        mac_clken <= 1'b1;
                    end
                    S_STEP: if (k == 2'd3) begin
                        state <= S_WAIT;
                        k     <= 2'd0;
                        wcnt  <= '0;
                    end else begin
                        state    <= S_IN;
                        k        <= k_nxt;
                        in_ready <= 1'b1;
                    end
                    S_WAIT: if (wcnt == WCW'(MAC_LAT - 1)) begin
                        state <= S_CAP;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                    S_CAP: begin
                        result    <= mac_out;
                        spike     <= (mac_out >= thr_q);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                    S_DONE: if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                    S_ABRT: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_frame_sequencer.sv
// Directed bench for mac_frame_sequencer with a small behavioural MAC.
module tb_mac_frame_sequencer;
    localparam int DW = 8, OW = 16, MAC_LAT = 2;

    logic          clk = 1'b0, rst = 1'b1;
    logic          w_wr = 1'b0;
    logic [1:0]    w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic [OW-1:0] thr = '0;
    logic          start = 1'b0, abort = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, spike, busy;
    logic [OW-1:0] result, mac_out;
    logic [DW-1:0] mac_in;
    logic          mac_ld, mac_ld1, mac_ld2, mac_ld3, mac_ld4, mac_clken, mac_rst;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mac_frame_sequencer #(.DW(DW), .OW(OW), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst), .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
        .thr(thr), .start(start), .abort(abort), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .spike(spike), .busy(busy),
        .mac_in(mac_in), .mac_ld(mac_ld), .mac_ld1(mac_ld1), .mac_ld2(mac_ld2),
        .mac_ld3(mac_ld3), .mac_ld4(mac_ld4), .mac_clken(mac_clken),
        .mac_rst(mac_rst), .mac_out(mac_out)
    );

    // Behavioural MAC: step n multiplies the loaded sample by weight n,
    // result appears MAC_LAT cycles after the accumulate edge.
    logic [7:0]  mw [4] = '{default: 8'd0};
    logic [7:0]  mx = 8'd0;
    logic [15:0] acc = 16'd0, p1 = 16'd0, p2 = 16'd0;
    logic [1:0]  mcnt = 2'd0;
    always @(posedge clk) begin
        if (mac_rst) begin acc <= 16'd0; mcnt <= 2'd0; end
        if (mac_ld1) mw[0] <= mac_in;
        if (mac_ld2) mw[1] <= mac_in;
        if (mac_ld3) mw[2] <= mac_in;
        if (mac_ld4) mw[3] <= mac_in;
        if (mac_ld) mx <= mac_in;
        if (mac_clken) begin
            acc  <= acc + 16'(mx) * 16'(mw[mcnt]);
            mcnt <= mcnt + 2'd1;
        end
        p1 <= acc;
        p2 <= p1;
    end
    assign mac_out = p2;

    // Pulse log: {code, mac_in}; codes 1=rst 2..5=ld1..ld4 6=ld 7=clken.
    logic [15:0] plog[$];
    int          ov_err = 0;
    int          npulse;
    always @(negedge clk) begin
        npulse = int'(mac_rst) + int'(mac_ld1) + int'(mac_ld2) + int'(mac_ld3) +
                 int'(mac_ld4) + int'(mac_ld) + int'(mac_clken);
        if (!rst) begin
            if (npulse > 1) ov_err++;
            if (npulse == 0 && mac_in != 8'd0) ov_err++;
            if (mac_rst)   plog.push_back({8'd1, mac_in});
            if (mac_ld1)   plog.push_back({8'd2, mac_in});
            if (mac_ld2)   plog.push_back({8'd3, mac_in});
            if (mac_ld3)   plog.push_back({8'd4, mac_in});
            if (mac_ld4)   plog.push_back({8'd5, mac_in});
            if (mac_ld)    plog.push_back({8'd6, mac_in});
            if (mac_clken) plog.push_back({8'd7, mac_in});
        end
    end

    task automatic write_w(input logic [1:0] a, input logic [7:0] d);
        w_wr = 1'b1; w_addr = a; w_data = d;
        @(posedge clk); #1;
        w_wr = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Starts a frame and feeds 4 samples. lat = index of the edge after which
    // out_valid is first seen (start edge = 0), -1 on timeout.
    // wr_cyc: 0 = weight write alongside start, n>0 = during cycle after edge n.
    task automatic run_frame(input logic [7:0] s0, s1, s2, s3,
                             input int stall_idx, stall_n, wr_cyc,
                             input logic [1:0] wa, input logic [7:0] wd,
                             output int lat);
        logic [7:0] s [4];
        int idx, stalled, e;
        logic acc_now;
        s = '{s0, s1, s2, s3};
        idx = 0; stalled = 0; lat = -1; e = 0;
        start = 1'b1; in_valid = 1'b1; in_data = s[0];
        if (wr_cyc == 0) begin w_wr = 1'b1; w_addr = wa; w_data = wd; end
        while (lat < 0 && e < 60) begin
            acc_now = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0; w_wr = 1'b0;
            if (acc_now) idx++;
            if (out_valid) lat = e;
            if (wr_cyc == e && e > 0) begin w_wr = 1'b1; w_addr = wa; w_data = wd; end
            if (idx >= 4) in_valid = 1'b0;
            else if (idx == stall_idx && in_ready && stalled < stall_n) begin
                in_valid = 1'b0; stalled++;
            end else begin
                in_valid = 1'b1; in_data = s[idx];
            end
            e++;
        end
        in_valid = 1'b0; w_wr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        total++; if ({mac_rst, mac_ld, mac_ld1, mac_ld2, mac_ld3, mac_ld4, mac_clken} !== 7'd0) begin
            bad++; $display("FAIL rst_ctl got=%b want=0", {mac_rst, mac_ld, mac_ld1, mac_ld2, mac_ld3, mac_ld4, mac_clken}); end
        total++; if ({out_valid, in_ready, spike, result, mac_in} !== '0) begin
            bad++; $display("FAIL rst_out got ov=%0b ir=%0b sp=%0b res=%0d in=%0d want all 0", out_valid, in_ready, spike, result, mac_in); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || mac_rst !== 1'b0) begin
            bad++; $display("FAIL idle_after_rst got busy=%0b mac_rst=%0b want 0", busy, mac_rst); end
    endtask

    task automatic test_zero_weights();
        int lat, base;
        thr = 16'd0; base = plog.size();
        run_frame(8'd1, 8'd2, 8'd3, 8'd4, -1, 0, -1, 2'd0, 8'd0, lat);
        total++; if (lat !== 16) begin bad++; $display("FAIL zero_lat got=%0d want=16", lat); end
        total++; if (result !== 16'd0 || spike !== 1'b1) begin
            bad++; $display("FAIL zero_res got res=%0d sp=%0b want res=0 sp=1", result, spike); end
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (plog.size() <= base + i || plog[base + i] !== {8'(i + 1), 8'd0}) begin
                bad++; $display("FAIL zero_ld%0d got=%h want=%h", i,
                                (plog.size() > base + i) ? plog[base + i] : 16'hxxxx, {8'(i + 1), 8'd0}); end
        end
        consume();
    endtask

    task automatic test_nominal();
        logic [15:0] exp_seq [13];
        int lat, base, ov0;
        exp_seq = '{16'h0100, 16'h0203, 16'h0305, 16'h0407, 16'h0509, 16'h0601, 16'h0700,
                    16'h0602, 16'h0700, 16'h0603, 16'h0700, 16'h0604, 16'h0700};
        write_w(2'd0, 8'd3); write_w(2'd1, 8'd5); write_w(2'd2, 8'd7); write_w(2'd3, 8'd9);
        thr = 16'd100; base = plog.size(); ov0 = ov_err;
        run_frame(8'd1, 8'd2, 8'd3, 8'd4, -1, 0, -1, 2'd0, 8'd0, lat);
        total++; if (lat !== 16) begin bad++; $display("FAIL nom_lat got=%0d want=16", lat); end
        total++; if (result !== 16'd70 || spike !== 1'b0) begin
            bad++; $display("FAIL nom_res got res=%0d sp=%0b want res=70 sp=0", result, spike); end
        total++; if (plog.size() - base !== 13) begin
            bad++; $display("FAIL nom_npulse got=%0d want=13", plog.size() - base); end
        for (int i = 0; i < 13; i++) begin
            total++;
            if (plog.size() <= base + i || plog[base + i] !== exp_seq[i]) begin
                bad++; $display("FAIL nom_seq%0d got=%h want=%h", i,
                                (plog.size() > base + i) ? plog[base + i] : 16'hxxxx, exp_seq[i]); end
        end
        total++; if (ov_err - ov0 !== 0) begin bad++; $display("FAIL nom_excl got=%0d want=0", ov_err - ov0); end
        consume();
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL nom_release got busy=%0b ov=%0b want 0", busy, out_valid); end
        thr = 16'd70;
        run_frame(8'd1, 8'd2, 8'd3, 8'd4, -1, 0, -1, 2'd0, 8'd0, lat);
        total++; if (result !== 16'd70 || spike !== 1'b1) begin
            bad++; $display("FAIL nom_thr_eq got res=%0d sp=%0b want res=70 sp=1", result, spike); end
        consume();
    endtask

    task automatic test_stall_backpressure();
        int lat, base;
        thr = 16'd100;
        run_frame(8'd1, 8'd2, 8'd3, 8'd4, 2, 3, -1, 2'd0, 8'd0, lat);
        total++; if (lat !== 19) begin bad++; $display("FAIL stall_lat got=%0d want=19", lat); end
        total++; if (result !== 16'd70) begin bad++; $display("FAIL stall_res got=%0d want=70", result); end
        base = plog.size(); start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || result !== 16'd70 || spike !== 1'b0) begin
                bad++; $display("FAIL hold%0d got ov=%0b busy=%0b res=%0d sp=%0b want 1 1 70 0",
                                c, out_valid, busy, result, spike); end
        end
        start = 1'b0;
        total++; if (plog.size() !== base) begin bad++; $display("FAIL start_ignored got=%0d want=0 pulses", plog.size() - base); end
        consume();
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL not_queued got busy=%0b want=0", busy); end
    endtask

    task automatic test_shadow_isolation();
        int lat, base;
        thr = 16'd100; base = plog.size();
        run_frame(8'd1, 8'd2, 8'd3, 8'd4, -1, 0, 5, 2'd1, 8'hFF, lat);
        total++; if (plog.size() <= base + 2 || plog[base + 2] !== 16'h0305) begin
            bad++; $display("FAIL shadow_cur got=%h want=0305", (plog.size() > base + 2) ? plog[base + 2] : 16'hxxxx); end
        total++; if (result !== 16'd70) begin bad++; $display("FAIL shadow_cur_res got=%0d want=70", result); end
        consume();
        base = plog.size();
        run_frame(8'd1, 8'd2, 8'd3, 8'd4, -1, 0, -1, 2'd0, 8'd0, lat);
        total++; if (plog.size() <= base + 2 || plog[base + 2] !== 16'h03FF) begin
            bad++; $display("FAIL shadow_next got=%h want=03ff", (plog.size() > base + 2) ? plog[base + 2] : 16'hxxxx); end
        total++; if (result !== 16'd570 || spike !== 1'b1) begin
            bad++; $display("FAIL shadow_next_res got res=%0d sp=%0b want 570 1", result, spike); end
        consume();
        base = plog.size();
        run_frame(8'd1, 8'd2, 8'd3, 8'd4, -1, 0, 0, 2'd1, 8'd5, lat);
        total++; if (plog.size() <= base + 2 || plog[base + 2] !== 16'h03FF) begin
            bad++; $display("FAIL shadow_startwr got=%h want=03ff", (plog.size() > base + 2) ? plog[base + 2] : 16'hxxxx); end
        consume();
    endtask

    task automatic test_abort();
        logic seen_ov, seen_ir;
        seen_ov = 1'b0; seen_ir = 1'b0;
        start = 1'b1; in_valid = 1'b1; in_data = 8'd1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (e == 10) begin
                total++; if (mac_clken !== 1'b1) begin bad++; $display("FAIL abort_in_step got clken=%0b want=1", mac_clken); end
                abort = 1'b1;
            end
            if (e == 11) begin
                abort = 1'b0; in_valid = 1'b0;
                total++; if (mac_rst !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
                    bad++; $display("FAIL abort_clr got rst=%0b busy=%0b ov=%0b want 1 1 0", mac_rst, busy, out_valid); end
            end
            if (e == 12) begin
                total++; if (mac_rst !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL abort_idle got rst=%0b busy=%0b want 0 0", mac_rst, busy); end
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            seen_ov |= out_valid; seen_ir |= in_ready;
        end
        total++; if (seen_ov !== 1'b0 || seen_ir !== 1'b0) begin
            bad++; $display("FAIL abort_quiet got ov=%0b ir=%0b want 0 0", seen_ov, seen_ir); end
        total++; if (result !== 16'd570 || spike !== 1'b1) begin
            bad++; $display("FAIL abort_keep got res=%0d sp=%0b want 570 1", result, spike); end
    endtask

    task automatic test_async_reset();
        int lat;
        thr = 16'd100;
        start = 1'b1; in_valid = 1'b1; in_data = 8'd2;
        for (int e = 0; e <= 13; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy got=%0b want=1", busy); end
        #2 rst = 1'b1;
        #1;
        total++; if ({busy, out_valid, in_ready, mac_rst, mac_ld1, mac_ld2, mac_ld3, mac_ld4,
                      mac_clken, mac_ld, spike} !== 11'd0 || result !== 16'd0 || mac_in !== 8'd0) begin
            bad++; $display("FAIL async_rst got busy=%0b ov=%0b res=%0d sp=%0b want all 0", busy, out_valid, result, spike); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        write_w(2'd0, 8'd3); write_w(2'd1, 8'd5); write_w(2'd2, 8'd7); write_w(2'd3, 8'd9);
        run_frame(8'd1, 8'd2, 8'd3, 8'd4, -1, 0, -1, 2'd0, 8'd0, lat);
        total++; if (lat !== 16 || result !== 16'd70 || spike !== 1'b0) begin
            bad++; $display("FAIL post_rst_frame got lat=%0d res=%0d sp=%0b want 16 70 0", lat, result, spike); end
        consume();
    endtask

    initial begin
        test_reset();
        test_zero_weights();
        test_nominal();
        test_stall_backpressure();
        test_shadow_isolation();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
